// File: rtl/alu_cmd_sequencer_if.sv
// Command/ALU/TX signal bundle for the ALU command sequencer.
// master = sequencer side, slave = RX source, ALU and TX FIFO side.
interface alu_cmd_sequencer_if #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * OPER_WIDTH,
  parameter int FUN_WIDTH  = 4
);
  logic [OPER_WIDTH-1:0] RX_DATA;
  logic                  RX_VALID;
  logic [OPER_WIDTH-1:0] ALU_A;
  logic [OPER_WIDTH-1:0] ALU_B;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  ALU_EN;
  logic [OUT_WIDTH-1:0]  ALU_OUT;
  logic                  ALU_OUT_VALID;
  logic [OPER_WIDTH-1:0] TX_DATA;
  logic                  TX_WR;
  logic                  TX_FULL;
  logic                  BUSY;
  logic                  ERR_CMD;
  logic                  ERR_OVR;

  modport master (
    input  RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_FULL,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_WR, BUSY, ERR_CMD, ERR_OVR
  );

  modport slave (
    output RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_FULL,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_DATA, TX_WR, BUSY, ERR_CMD, ERR_OVR
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Collects {CMD, A, B} from RX, runs one ALU operation and streams the
// result to the TX FIFO as two bytes, LSB first, honouring TX_FULL.
module alu_cmd_sequencer #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * OPER_WIDTH,
  parameter int FUN_WIDTH  = 4,
  parameter int TIMEOUT    = 15
) (
  input logic                CLK,
  input logic                RST,
  alu_cmd_sequencer_if.master bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_A, S_GET_B, S_EXEC, S_WAIT, S_SEND_LO, S_SEND_HI
  } state_t;

  state_t                state_reg;
  logic [OPER_WIDTH-1:0] alu_a_reg;
  logic [OPER_WIDTH-1:0] alu_b_reg;
  logic [FUN_WIDTH-1:0]  alu_fun_reg;
  logic                  alu_en_reg;
  logic [OUT_WIDTH-1:0]  result_reg;
  logic [CNT_W-1:0]      timeout_cnt_reg;
  logic                  err_cmd_reg;
  logic                  err_ovr_reg;
  logic                  rx_busy;
  logic                  cmd_legal;
  logic [OPER_WIDTH-1:0] tx_byte;

  // States in which an incoming byte cannot be accepted and is dropped
  assign rx_busy   = (state_reg == S_EXEC) || (state_reg == S_WAIT) ||
                     (state_reg == S_SEND_LO) || (state_reg == S_SEND_HI);
  assign cmd_legal = (bus.RX_DATA[7:4] == 4'h0) && (bus.RX_DATA[3:0] != 4'hF);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= S_IDLE;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_fun_reg     <= '0;
      alu_en_reg      <= 1'b0;
      result_reg      <= '0;
      timeout_cnt_reg <= '0;
      err_cmd_reg     <= 1'b0;
      err_ovr_reg     <= 1'b0;
    end else begin
      alu_en_reg  <= 1'b0;
      err_cmd_reg <= 1'b0;
      err_ovr_reg <= bus.RX_VALID && rx_busy;
      case (state_reg)
        S_IDLE: begin
          if (bus.RX_VALID) begin
            if (cmd_legal) begin
              alu_fun_reg <= bus.RX_DATA[FUN_WIDTH-1:0];
              state_reg   <= S_GET_A;
            end else begin
              err_cmd_reg <= 1'b1;
            end
          end
        end
        S_GET_A: begin
          if (bus.RX_VALID) begin
            alu_a_reg <= bus.RX_DATA;
            state_reg <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (bus.RX_VALID) begin
            alu_b_reg  <= bus.RX_DATA;
            alu_en_reg <= 1'b1;
            state_reg  <= S_EXEC;
          end
        end
        S_EXEC: begin
          timeout_cnt_reg <= '0;
          state_reg       <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ALU_OUT_VALID) begin
            result_reg <= bus.ALU_OUT;
            state_reg  <= S_SEND_LO;
          end else if (timeout_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            err_ovr_reg <= 1'b1;
            state_reg   <= S_IDLE;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
        end
        S_SEND_LO: begin
          if (!bus.TX_FULL) state_reg <= S_SEND_HI;
        end
        S_SEND_HI: begin
          if (!bus.TX_FULL) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Byte lane select: the result is split purely by bit position
  genvar gi;
  generate
    for (gi = 0; gi < OPER_WIDTH; gi++) begin : g_tx_lane
      assign tx_byte[gi] = (state_reg == S_SEND_HI) ? result_reg[OPER_WIDTH + gi]
                                                    : result_reg[gi];
    end
  endgenerate

  assign bus.ALU_A   = alu_a_reg;
  assign bus.ALU_B   = alu_b_reg;
  assign bus.ALU_FUN = alu_fun_reg;
  assign bus.ALU_EN  = alu_en_reg;
  assign bus.TX_DATA = tx_byte;
  assign bus.TX_WR   = ((state_reg == S_SEND_LO) || (state_reg == S_SEND_HI)) && !bus.TX_FULL;
  assign bus.BUSY    = (state_reg != S_IDLE);
  assign bus.ERR_CMD = err_cmd_reg;
  assign bus.ERR_OVR = err_ovr_reg;

endmodule
